// File: rtl/bit_serial_sequencer.sv
// Control FSM for the bit-serial matrix-vector datapath: loads operands, steps the
// bit slicer through every bit position, drains the PE pipeline and holds done.
module bit_serial_sequencer #(
  parameter int NUM_BITS   = 16,
  parameter int PE_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  input  logic       abort,
  input  logic       done_ack,
  output logic       ready,
  output logic       busy,
  output logic       load_a,
  output logic       pe_clear,
  output logic       pe_en,
  output logic [3:0] bit_counter,
  output logic       last_bit,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_e;

  localparam logic [3:0] LastBitIdx = 4'(NUM_BITS - 1);
  localparam logic [2:0] DrainInit  = 3'(PE_LATENCY);
  localparam bit         NoDrain    = (PE_LATENCY == 0);

  state_e     state_q, state_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] drain_q, drain_d;
  logic       ready_q, busy_q, load_q, run_q, last_q, done_q;

  // Next-state logic; abort overrides every transition except leaving IDLE.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        bit_d = 4'd0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        bit_d   = 4'd0;
        state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (bit_q != LastBitIdx) begin
            bit_d = bit_q + 4'd1;
          end else if (NoDrain) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
            drain_d = DrainInit;
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - 3'd1;
        if (drain_q == 3'd1) state_d = DONE;
      end
      DONE: begin
        if (done_ack) begin
          state_d = IDLE;
          bit_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = 4'd0;
        drain_d = 3'd0;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      bit_d   = 4'd0;
      drain_d = 3'd0;
    end
  end

  // Output flags are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= 4'd0;
      drain_q <= 3'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      drain_q <= drain_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      load_q  <= (state_d == LOAD);
      run_q   <= (state_d == RUN);
      last_q  <= (state_d == RUN) && (bit_d == LastBitIdx);
      done_q  <= (state_d == DONE);
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign load_a      = load_q;
  assign pe_clear    = load_q;
  assign pe_en       = run_q & ~stall;
  assign bit_counter = bit_q;
  assign last_bit    = last_q;
  assign done        = done_q;

endmodule

// File: tb/tb_bit_serial_sequencer.sv
// Bench for bit_serial_sequencer: expected per-cycle traces are built from the
// operation timeline (load, per-bit steps with stalls, drain, done) and compared.
module tb_bit_serial_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start, stall, abort, doneAck;
  logic [2:0] ready, busy, loadA, peClear, peEn, lastBit, done;
  logic [3:0] bitCounter [3];

  int nAsserts = 0;
  int nFails   = 0;

  typedef struct {
    logic        drvStart;
    logic        drvStall;
    logic        drvAbort;
    logic        drvAck;
    logic [10:0] exp;
  } step_t;

  step_t trace[$];

  bit_serial_sequencer #(.NUM_BITS(16), .PE_LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .stall(stall[0]), .abort(abort[0]),
    .done_ack(doneAck[0]), .ready(ready[0]), .busy(busy[0]), .load_a(loadA[0]),
    .pe_clear(peClear[0]), .pe_en(peEn[0]), .bit_counter(bitCounter[0]),
    .last_bit(lastBit[0]), .done(done[0]));

  bit_serial_sequencer #(.NUM_BITS(1), .PE_LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .stall(stall[1]), .abort(abort[1]),
    .done_ack(doneAck[1]), .ready(ready[1]), .busy(busy[1]), .load_a(loadA[1]),
    .pe_clear(peClear[1]), .pe_en(peEn[1]), .bit_counter(bitCounter[1]),
    .last_bit(lastBit[1]), .done(done[1]));

  bit_serial_sequencer #(.NUM_BITS(16), .PE_LATENCY(7)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .stall(stall[2]), .abort(abort[2]),
    .done_ack(doneAck[2]), .ready(ready[2]), .busy(busy[2]), .load_a(loadA[2]),
    .pe_clear(peClear[2]), .pe_en(peEn[2]), .bit_counter(bitCounter[2]),
    .last_bit(lastBit[2]), .done(done[2]));

  // Packing order: ready, busy, load_a, pe_clear, pe_en, last_bit, done, bit_counter.
  function automatic logic [10:0] expv(input bit rd, input bit bs, input bit ld,
                                       input bit pe, input bit lb, input bit dn,
                                       input int bc);
    return {rd, bs, ld, ld, pe, lb, dn, 4'(bc)};
  endfunction

  function automatic step_t mk(input bit s, input bit st, input bit ab, input bit ak,
                               input logic [10:0] e);
    step_t r;
    r.drvStart = s;
    r.drvStall = st;
    r.drvAbort = ab;
    r.drvAck   = ak;
    r.exp      = e;
    return r;
  endfunction

  function automatic bit rnd(input bit noise);
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // abortKind: 0 none, 1 at the first cycle with bit 7 in RUN, 2 at the first DRAIN cycle.
  task automatic buildTrace(input int nb, input int lat, input int stalls[16],
                            input int ackDelay, input int abortKind, input bit noise);
    int abortIdx;
    bit lb;
    abortIdx = -1;
    trace.delete();
    trace.push_back(mk(1'b1, rnd(noise), rnd(noise), rnd(noise), expv(1, 0, 0, 0, 0, 0, 0)));
    trace.push_back(mk(rnd(noise), rnd(noise), 1'b0, rnd(noise), expv(0, 1, 1, 0, 0, 0, 0)));
    for (int b = 0; b < nb; b++) begin
      lb = (b == nb - 1);
      for (int s = 0; s < stalls[b]; s++) begin
        trace.push_back(mk(rnd(noise), 1'b1, 1'b0, rnd(noise), expv(0, 1, 0, 0, lb, 0, b)));
        if (abortKind == 1 && b == 7 && abortIdx < 0) abortIdx = trace.size() - 1;
      end
      trace.push_back(mk(rnd(noise), 1'b0, 1'b0, rnd(noise), expv(0, 1, 0, 1, lb, 0, b)));
      if (abortKind == 1 && b == 7 && abortIdx < 0) abortIdx = trace.size() - 1;
    end
    for (int d = 0; d < lat; d++) begin
      trace.push_back(mk(rnd(noise), rnd(noise), 1'b0, rnd(noise), expv(0, 1, 0, 0, 0, 0, nb - 1)));
      if (abortKind == 2 && d == 0) abortIdx = trace.size() - 1;
    end
    for (int a = 0; a < ackDelay; a++)
      trace.push_back(mk((a % 3 == 1) | rnd(noise), rnd(noise), 1'b0, 1'b0,
                         expv(0, 1, 0, 0, 0, 1, nb - 1)));
    trace.push_back(mk(rnd(noise), rnd(noise), 1'b0, 1'b1, expv(0, 1, 0, 0, 0, 1, nb - 1)));
    if (abortIdx >= 0) begin
      trace = trace[0:abortIdx];
      trace[abortIdx].drvAbort = 1'b1;
    end
    trace.push_back(mk(1'b0, rnd(noise), 1'b0, rnd(noise), expv(1, 0, 0, 0, 0, 0, 0)));
  endtask

  task automatic checkOutput(input int k, input string tag, input int idx,
                             input logic [10:0] exp);
    logic [10:0] obs;
    obs = {ready[k], busy[k], loadA[k], peClear[k], peEn[k], lastBit[k], done[k],
           bitCounter[k]};
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s inst %0d step %0d observed %h expected %h", tag, k, idx, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input string tag, input int lastIdx,
                               input bit rstAtLast, output int firstDone);
    firstDone = -1;
    for (int i = 0; i <= lastIdx; i++) begin
      start[k]   = trace[i].drvStart;
      stall[k]   = trace[i].drvStall;
      abort[k]   = trace[i].drvAbort;
      doneAck[k] = trace[i].drvAck;
      if (rstAtLast && i == lastIdx) rst = 1'b1;
      #1;
      checkOutput(k, tag, i, trace[i].exp);
      if (done[k] === 1'b1 && firstDone < 0) firstDone = i;
      @(posedge clk);
      #1;
    end
    start[k]   = 1'b0;
    stall[k]   = 1'b0;
    abort[k]   = 1'b0;
    doneAck[k] = 1'b0;
  endtask

  task automatic runOp(input string tag, input int k, input int nb, input int lat,
                       input int stalls[16], input int ackDelay, input int abortKind,
                       input bit noise);
    int fd;
    int total;
    total = 0;
    for (int b = 0; b < nb; b++) total += stalls[b];
    buildTrace(nb, lat, stalls, ackDelay, abortKind, noise);
    applyStimulus(k, tag, trace.size() - 1, 1'b0, fd);
    nAsserts++;
    if (abortKind == 0) begin
      assert (fd === 2 + nb + lat + total) else begin
        nFails++;
        $error("[TB] FAIL %s_latency inst %0d observed %0d expected %0d", tag, k, fd,
               2 + nb + lat + total);
      end
    end else begin
      assert (fd === -1) else begin
        nFails++;
        $error("[TB] FAIL %s_nodone inst %0d observed %0d expected %0d", tag, k, fd, -1);
      end
    end
  endtask

  initial begin
    int st[16];
    int fd;
    logic [10:0] resetVal;
    resetVal = expv(1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    start = '0;
    stall = '0;
    abort = '0;
    doneAck = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) checkOutput(k, "reset", 0, resetVal);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int b = 0; b < 16; b++) st[b] = 0;
    runOp("basic", 0, 16, 2, st, 0, 0, 1'b0);

    st[5] = 3;
    st[15] = 1;
    runOp("stall", 0, 16, 2, st, 0, 0, 1'b0);
    for (int b = 0; b < 16; b++) st[b] = 0;

    runOp("heldDone", 0, 16, 2, st, 10, 0, 1'b0);
    runOp("abortRun", 0, 16, 2, st, 0, 1, 1'b0);
    runOp("afterAbortRun", 0, 16, 2, st, 0, 0, 1'b0);
    runOp("abortDrain", 0, 16, 2, st, 0, 2, 1'b0);
    runOp("afterAbortDrain", 0, 16, 2, st, 0, 0, 1'b0);

    buildTrace(16, 2, st, 0, 0, 1'b0);
    applyStimulus(0, "midReset", 12, 1'b1, fd);
    checkOutput(0, "resetValues", 13, resetVal);
    rst = 1'b0;
    runOp("afterReset", 0, 16, 2, st, 0, 0, 1'b0);

    runOp("corner1x0", 1, 1, 0, st, 0, 0, 1'b0);
    runOp("corner16x7", 2, 16, 7, st, 0, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      for (int b = 0; b < 16; b++)
        st[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      runOp("random", n % 3, (n % 3 == 1) ? 1 : 16, (n % 3 == 0) ? 2 : ((n % 3 == 1) ? 0 : 7),
            st, int'($urandom_range(0, 3)), 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
